// File: rtl/einstein_sd_pkg.sv
`default_nettype none
// ============================================================================
// Module : einstein_sd_pkg
// Brief  : Shared types and sizes for the Einstein SD sector arbiter.
// Rev    : 1.0
// ============================================================================
package einstein_sd_pkg;

    localparam int NUM_DRV      = 2;
    localparam int SECTOR_BYTES = 512;
    localparam int LBA_W        = 32;
    localparam int BUFF_AW      = $clog2(SECTOR_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [NUM_DRV-1:0] drv_onehot(input logic drv);
        return drv ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_sector_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : sd_sector_arbiter_if
// Brief  : mist_io SD sector channel (request, ack and 512-byte buffer port).
// Rev    : 1.0
// ============================================================================
interface sd_sector_arbiter_if;
    import einstein_sd_pkg::*;

    logic [LBA_W-1:0]   sd_lba;
    logic [NUM_DRV-1:0] sd_rd;
    logic [NUM_DRV-1:0] sd_wr;
    logic               sd_ack;
    logic [BUFF_AW-1:0] sd_buff_addr;
    logic [7:0]         sd_buff_dout;
    logic [7:0]         sd_buff_din;
    logic               sd_buff_wr;

    // Arbiter side issues requests; mist_io side answers them.
    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );

endinterface
`default_nettype wire

// File: rtl/sd_sector_arbiter.sv
`default_nettype none
// ============================================================================
// Module : sd_sector_arbiter
// Brief  : Round-robin share of the mist_io SD sector channel between two drives.
// Rev    : 1.0
// ============================================================================
module sd_sector_arbiter
    import einstein_sd_pkg::*;
#(
    parameter int TIMEOUT_W = 24
) (
    input  wire logic                     clk_sys,
    input  wire logic                     reset,
    input  wire logic [NUM_DRV-1:0]       img_mounted,
    input  wire logic [31:0]              img_size,
    input  wire logic [NUM_DRV*LBA_W-1:0] drv_lba,
    input  wire logic [NUM_DRV-1:0]       drv_rd,
    input  wire logic [NUM_DRV-1:0]       drv_wr,
    output logic      [NUM_DRV-1:0]       drv_busy,
    output logic      [NUM_DRV-1:0]       drv_done,
    output logic                          drv_err,
    output logic      [BUFF_AW-1:0]       drv_buff_addr,
    output logic      [7:0]               drv_buff_dout,
    output logic      [NUM_DRV-1:0]       drv_buff_wr,
    input  wire logic [NUM_DRV*8-1:0]     drv_buff_din,
    sd_sector_arbiter_if.master           sd
);

    state_t               state;
    state_t               state_nxt;

    logic [NUM_DRV-1:0]   rdy;
    logic                 last;
    logic                 gnt;
    logic                 op_wr;
    logic                 err_q;
    logic [LBA_W-1:0]     lba_q;
    logic [TIMEOUT_W-1:0] wdog;

    logic [NUM_DRV-1:0]   cand;
    logic                 req_any;
    logic                 pick;
    logic                 pick_rdy;
    logic [TIMEOUT_W-1:0] wdog_inc;
    logic                 wdog_hit;
    logic [NUM_DRV-1:0]   gnt_oh;

    // Two contenders: the one not served last wins; otherwise the lone requester.
    assign cand     = drv_rd | drv_wr;
    assign req_any  = |cand;
    assign pick     = (cand == 2'b11) ? ~last : cand[1];
    assign pick_rdy = rdy[pick];
    assign wdog_inc = wdog + 1'b1;
    assign wdog_hit = &wdog_inc;
    assign gnt_oh   = drv_onehot(gnt);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt = pick_rdy ? REQ : DONE;
                end
            end
            REQ: begin
                if (sd.sd_ack) begin
                    state_nxt = XFER;
                end else if (wdog_hit) begin
                    state_nxt = DONE;
                end
            end
            XFER: begin
                if (!sd.sd_ack) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rdy   <= '0;
            last  <= 1'b1;
            gnt   <= 1'b0;
            op_wr <= 1'b0;
            err_q <= 1'b0;
            lba_q <= '0;
            wdog  <= '0;
        end else begin
            for (int i = 0; i < NUM_DRV; i++) begin
                if (img_mounted[i]) begin
                    rdy[i] <= |img_size;
                end
            end

            case (state)
                IDLE: begin
                    if (req_any) begin
                        gnt   <= pick;
                        err_q <= ~pick_rdy;
                        wdog  <= '0;
                        if (pick_rdy) begin
                            lba_q <= pick ? drv_lba[2*LBA_W-1:LBA_W] : drv_lba[LBA_W-1:0];
                            op_wr <= ~drv_rd[pick];
                            last  <= pick;
                        end
                    end
                end
                REQ: begin
                    // Stepping onto all-ones ends the wait, so the count never wraps.
                    if (!sd.sd_ack) begin
                        wdog <= wdog_inc;
                        if (wdog_hit) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sd.sd_lba = lba_q;

    always_comb begin
        drv_busy       = '0;
        drv_done       = '0;
        drv_err        = 1'b0;
        drv_buff_addr  = '0;
        drv_buff_dout  = '0;
        drv_buff_wr    = '0;
        sd.sd_rd       = '0;
        sd.sd_wr       = '0;
        sd.sd_buff_din = '0;

        if (state != IDLE) begin
            drv_busy = gnt_oh;
        end

        case (state)
            REQ: begin
                if (op_wr) begin
                    sd.sd_wr = gnt_oh;
                end else begin
                    sd.sd_rd = gnt_oh;
                end
            end
            XFER: begin
                drv_buff_addr  = sd.sd_buff_addr;
                drv_buff_dout  = sd.sd_buff_dout;
                drv_buff_wr    = sd.sd_buff_wr ? gnt_oh : '0;
                sd.sd_buff_din = gnt ? drv_buff_din[15:8] : drv_buff_din[7:0];
            end
            DONE: begin
                drv_done = gnt_oh;
                drv_err  = err_q;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
